// File: rtl/tcb_dec_rsp.sv
// TCB address decoder with registered response routing and local error termination.
// Optional stall timeout/abort is built when TCB_DEC_RSP_TIMEOUT_EN is defined.
module tcb_dec_rsp #(
    parameter  int unsigned                AW  = 32,
    parameter  int unsigned                DW  = 32,
    parameter  int unsigned                PN  = 3,
    parameter  int unsigned                DLY = 1,
    parameter  logic [PN-1:0][AW-1:0]      AV  = '0,
    parameter  logic [PN-1:0][AW-1:0]      AM  = '0,
    parameter  int unsigned                TMO = 16,
    localparam int unsigned                BW  = DW/8
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sub_vld,
    input  logic                   sub_wen,
    input  logic [AW-1:0]          sub_adr,
    input  logic [BW-1:0]          sub_ben,
    input  logic [DW-1:0]          sub_wdt,
    output logic [DW-1:0]          sub_rdt,
    output logic                   sub_err,
    output logic                   sub_rdy,
    output logic [PN-1:0]          man_vld,
    output logic                   man_wen,
    output logic [AW-1:0]          man_adr,
    output logic [BW-1:0]          man_ben,
    output logic [DW-1:0]          man_wdt,
    input  logic [PN-1:0][DW-1:0]  man_rdt,
    input  logic [PN-1:0]          man_err,
    input  logic [PN-1:0]          man_rdy,
    output logic                   sts_dec,
    output logic                   sts_tmo
);

    localparam int unsigned SW = (PN > 1) ? $clog2(PN) : 1;

    // Returns {hit, index}; scanning downwards lets the lowest matching port win.
    function automatic logic [SW:0] decode(input logic [AW-1:0] adr);
        logic [SW:0] res;
        res = '0;
        for (int i = int'(PN) - 1; i >= 0; i--) begin
            res = ((adr & AM[i]) == (AV[i] & AM[i])) ? {1'b1, SW'(i)} : res;
        end
        return res;
    endfunction

    logic [SW:0]   dec_s;
    logic          hit_s;
    logic [SW-1:0] sel_s;
    logic          abort_s;
    logic          hsk_s;
    logic          loc_s;

    logic [DLY-1:0] vld_r;
    logic [DLY-1:0] loc_r;
    logic [SW-1:0]  src_r [DLY];

    assign dec_s   = decode(sub_adr);
    assign hit_s   = dec_s[SW];
    assign sel_s   = dec_s[SW-1:0];
    assign hsk_s   = sub_vld & sub_rdy;
    assign loc_s   = ~hit_s | abort_s;
    assign sts_dec = sub_vld & ~hit_s;
    assign sts_tmo = abort_s;

    assign man_wen = sub_wen;
    assign man_adr = sub_adr;
    assign man_ben = sub_ben;
    assign man_wdt = sub_wdt;

`ifdef TCB_DEC_RSP_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TMO + 1);
    logic [TW-1:0] tmo_cnt_r;

    // An abort forces a handshake, so the counter can never run past TMO.
    assign abort_s = sub_vld & hit_s & (tmo_cnt_r == TW'(TMO));

    // Stall counter: counts consecutive mapped cycles without a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if (sub_vld && hit_s && !hsk_s) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end
`else
    assign abort_s = 1'b0;
`endif

    // Request steering and acceptance toward the selected manager port.
    always_comb begin
        man_vld = '0;
        sub_rdy = 1'b1;
        if (sub_vld && hit_s && !abort_s) begin
            man_vld[sel_s] = 1'b1;
        end else begin
            man_vld = '0;
        end
        if (hit_s) begin
            sub_rdy = man_rdy[sel_s] | abort_s;
        end else begin
            sub_rdy = 1'b1;
        end
    end

    // Response tracking shift register; one slot per cycle, empty when no handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= '0;
            loc_r <= '0;
            for (int i = 0; i < int'(DLY); i++) begin
                src_r[i] <= '0;
            end
        end else begin
            vld_r[0] <= hsk_s;
            loc_r[0] <= loc_s;
            src_r[0] <= sel_s;
            for (int i = 1; i < int'(DLY); i++) begin
                vld_r[i] <= vld_r[i-1];
                loc_r[i] <= loc_r[i-1];
                src_r[i] <= src_r[i-1];
            end
        end
    end

    // Response mux from the oldest slot: port data, local error, or idle zeros.
    always_comb begin
        sub_rdt = '0;
        sub_err = 1'b0;
        if (vld_r[DLY-1]) begin
            if (loc_r[DLY-1]) begin
                sub_rdt = '0;
                sub_err = 1'b1;
            end else begin
                sub_rdt = man_rdt[src_r[DLY-1]];
                sub_err = man_err[src_r[DLY-1]];
            end
        end else begin
            sub_rdt = '0;
            sub_err = 1'b0;
        end
    end

endmodule

// File: doc/tcb_dec_rsp.md
# tcb_dec_rsp

Parametrised TCB address decoder that fans one subordinate-side request (from the CPU) out to PN manager ports (memory, GPIO, UART, ...), with registered response routing. Unmapped accesses and stalled peripherals are terminated locally with an error response. It replaces the plain decoder plus per-slot error stubs in the SoC top, and gives the CPU a guaranteed bounded-latency bus.

## Interface
Parameters:
- `AW`, 32: address width (byte address).
- `DW`, 32: data width; `BW = DW/8` byte enables.
- `PN`, 3: number of manager ports, 1..16.
- `DLY`, 1: response delay in cycles after handshake, ≥1, identical on all ports.
- `AV`, `'0`: `[PN-1:0][AW-1:0]` match value per port.
- `AM`, `'0`: `[PN-1:0][AW-1:0]` match mask per port (1 = bit compared).
- `TMO`, 16: stall timeout in cycles, ≥1. Used only with the timeout feature.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `sub_vld`, `sub_wen`, input, 1 each: request valid, write enable.
- `sub_adr`, input, AW: request address.
- `sub_ben`, input, BW: byte enables.
- `sub_wdt`, input, DW: write data.
- `sub_rdt`, output, DW: read data.
- `sub_err`, output, 1: error response.
- `sub_rdy`, output, 1: request accepted.
- `man_vld`, output, PN: per-port request valid.
- `man_wen`, `man_adr`, `man_ben`, `man_wdt`, output: broadcast copies of the request fields.
- `man_rdt`, input, PN×DW: per-port read data.
- `man_err`, input, PN: per-port error.
- `man_rdy`, input, PN: per-port ready.
- `sts_dec`, output, 1: one-cycle pulse on an unmapped handshake.
- `sts_tmo`, output, 1: one-cycle pulse on a timeout abort.

## Operation
- **Decode:** port i matches when `(sub_adr & AM[i]) == (AV[i] & AM[i])`. The lowest matching index wins.
- **Unmapped:** no port matches.
- **Mapped request, combinational:**
  - `man_vld[sel] = sub_vld & ~abort`; all other `man_vld` bits are 0.
  - `sub_rdy = man_rdy[sel] | abort`.
- **Unmapped request:** `sub_rdy = 1`, all `man_vld = 0`, `sts_dec = sub_vld`.
- **Handshake:** `sub_vld & sub_rdy`.
- **Response tracking:** each handshake pushes `{valid=1, src}` into a DLY-stage shift register. `src` is either the port index or LOCAL (unmapped or abort). A non-handshake cycle pushes `valid=0`.
- **Stage DLY output:**
  - valid, port src: `sub_rdt = man_rdt[src]`, `sub_err = man_err[src]`.
  - valid, LOCAL: `sub_rdt = 0`, `sub_err = 1`.
  - not valid: `sub_rdt = 0`, `sub_err = 0`.
- **Back-to-back handshakes:** one per cycle is allowed, including port switches. No gap cycles are inserted.
- Writes produce a response slot too; `sub_err` is meaningful for them and `sub_rdt` is don't-care.

## Timing
- **Reset values:** shift register valid bits 0, timeout counter 0, so `sub_rdt = 0`, `sub_err = 0`, `sts_tmo = 0`.
- Outputs derived combinationally from `sub_vld` (`sub_rdy`, `man_vld`, `sts_dec`) follow their inputs even during reset.
- **Response latency:** exactly DLY cycles after the handshake cycle, for every source including LOCAL.
- **Reset mid-operation:** pending responses are discarded and no `sub_err` is emitted afterwards. Requests in the reset cycle still pass combinationally.
- **Timeout counter:**
  - Width `$clog2(TMO+1)`.
  - Increments each cycle with `sub_vld=1`, a mapped request, and no handshake.
  - Clears on a handshake or when `sub_vld=0`.
- **Abort:** asserted when `counter == TMO`, i.e. in the (TMO+1)-th stalled cycle. In that cycle:
  - `man_vld[sel] = 0`, `sub_rdy = 1`, `sts_tmo = 1`.
  - A LOCAL slot is pushed; the counter clears the next cycle.
- **Simultaneous events:** if `man_rdy[sel]` rises in the abort cycle, the abort wins and the peripheral sees no `vld`.

## Configuration
- Macro: `TCB_DEC_RSP_TIMEOUT_EN`.
- **Defined:** timeout counter and abort as above; `TMO` is honoured.
- **Undefined:**
  - No counter is built; `abort` is tied to 0 and `sts_tmo` to 0.
  - A stalled port stalls `sub` indefinitely.
  - `TMO` is ignored.

## Test plan
- **Mapped read:** PN=3, AV={0x0,0x8000_0000,0x8000_0040}, AM={0x8000_0000,0x8000_0040,0x8000_0040}, DLY=1.
  - Stimulus: read 0x8000_0044 with port 2 rdt=0xCAFE_F00D.
  - Required: `man_vld=3'b100` and `sub_rdy=1` the same cycle; next cycle `sub_rdt=0xCAFE_F00D`, `sub_err=0`.
- **Back-to-back port switch:** read port 0 (rdt 0x11), then port 1 (rdt 0x22) on consecutive cycles with DLY=2.
  - Required: `sub_rdt` = 0x11, then 0x22, on cycles +2 and +3.
- **Unmapped:** with AM[0] narrowed to AV[0]=0x0, AM[0]=0xF000_0000, write to 0x4000_0000.
  - Required: `sub_rdy=1` and `sts_dec=1` immediately, all `man_vld=0`; DLY cycles later `sub_err=1`, `sub_rdt=0`.
- **Timeout:** macro defined, TMO=4, port 1 rdy held 0.
  - Required: `sub_rdy=0` for 4 cycles; in the 5th, `sub_rdy=1`, `man_vld=0`, `sts_tmo=1`; DLY later `sub_err=1`.
  - Same stimulus with the macro undefined: `sub_rdy` stays 0 for 100 cycles.
- **Reset mid-operation:** handshake to port 0 at DLY=2, `rst=1` in the following cycle.
  - Required: `sub_err=0` and `sub_rdt=0` for the 3 cycles after reset; no stale response appears.
- **Slave error passthrough:** port 1 returns `man_err=1` on a read.
  - Required: `sub_err=1` DLY cycles after the handshake and `sts_dec=0`.
